// File: rtl/riscboy_ppu_bus_arbiter.sv
// riscboy_ppu_bus_arbiter
// Round-robin arbiter that shares the single PPU memory read port between
// N_REQ fetch engines. The winning request is registered onto the memory
// port. The response is routed back to the granted requester only. The next
// grant is issued in the completion cycle, so back-to-back transfers have no
// bubble between them.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   req_vld     per-requester request valid                  [N_REQ]
//   req_addr    per-requester address, k at [k*W_ADDR +: W_ADDR]
//   req_size    per-requester size (0 byte/1 half/2 word), k at [2k +: 2]
//   req_rdy     one-hot completion pulse to the granted requester
//   req_data    read data broadcast to all requesters (valid with req_rdy)
//   mem_vld     memory request valid
//   mem_addr    memory address (held for the whole transfer)
//   mem_size    memory transfer size (forwarded unchanged)
//   mem_rdy     memory completion pulse, mem_data valid this cycle
//   mem_data    memory read data
module riscboy_ppu_bus_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*W_ADDR-1:0] req_addr,
  input  logic [N_REQ*2-1:0]      req_size,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [W_DATA-1:0]       req_data,
  output logic                    mem_vld,
  output logic [W_ADDR-1:0]       mem_addr,
  output logic [1:0]              mem_size,
  input  logic                    mem_rdy,
  input  logic [W_DATA-1:0]       mem_data
);

  localparam int unsigned W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [W_IDX-1:0]   gnt;
  logic [W_IDX-1:0]   last;
  logic [W_IDX-1:0]   win_idx;
  logic [W_IDX-1:0]   idx;
  logic               win_found;
  logic               grant_en;
  logic               complete;
  logic [N_REQ-1:0]   elig;

  // Completion cycle; the finishing requester still holds vld, so mask it out
  always_comb begin
    complete = (state == BUSY) && mem_rdy;
    elig     = req_vld;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (complete && (gnt == W_IDX'(i))) begin
        elig[i] = 1'b0;
      end
    end
  end

  // Rotating priority search starting at last+1 (wrapping at N_REQ)
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = last;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (idx == W_IDX'(N_REQ - 1)) ? '0 : idx + W_IDX'(1);
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BUSY;
          grant_en  = 1'b1;
        end
      end
      BUSY: begin
        if (mem_rdy) begin
          if (win_found) begin
            grant_en = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture: winner index and its request fields, held until completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      last     <= W_IDX'(N_REQ - 1);
      mem_addr <= '0;
      mem_size <= '0;
    end else if (grant_en) begin
      gnt      <= win_idx;
      last     <= win_idx;
      mem_addr <= req_addr[32'(win_idx) * W_ADDR +: W_ADDR];
      mem_size <= req_size[32'(win_idx) * 2 +: 2];
    end
  end

  // Outputs: request valid from state, response routed to the granted requester
  always_comb begin
    mem_vld  = (state == BUSY);
    req_data = mem_data;
    req_rdy  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_rdy[i] = complete && (gnt == W_IDX'(i));
    end
  end

endmodule

// File: tb/tb_riscboy_ppu_bus_arbiter.sv
// tb_riscboy_ppu_bus_arbiter
// Self-checking bench for riscboy_ppu_bus_arbiter with three requesters.
// A behavioural model (rotating priority list, transfer log queue) predicts
// the memory port and the response routing every cycle. Directed scenarios
// cover reset, latency, contention, fairness, early drop and mid-transfer
// reset, followed by a randomized run.
module tb_riscboy_ppu_bus_arbiter;

  localparam int N  = 3;
  localparam int WA = 32;
  localparam int WD = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld;
  logic [N*WA-1:0] req_addr;
  logic [N*2-1:0]  req_size;
  logic [N-1:0]    req_rdy;
  logic [WD-1:0]   req_data;
  logic            mem_vld;
  logic [WA-1:0]   mem_addr;
  logic [1:0]      mem_size;
  logic            mem_rdy;
  logic [WD-1:0]   mem_data;

  riscboy_ppu_bus_arbiter #(.N_REQ(N), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_rdy  (req_rdy),
    .req_data (req_data),
    .mem_vld  (mem_vld),
    .mem_addr (mem_addr),
    .mem_size (mem_size),
    .mem_rdy  (mem_rdy),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_busy;
  int          m_gnt;
  int          m_last;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  int          done_q[$];

  // memory model / monitors
  int          mem_mode;   // 0 fastest, 1 random latency + idle noise, 2 stall
  int          mem_cnt;
  int          gap_mon;
  int          gap_cnt;
  logic [N-1:0] last_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic int qat(input int i);
    if (i < done_q.size()) return done_q[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_gnt   = 0;
    m_last  = N - 1;
    m_addr  = '0;
    m_size  = '0;
    mem_cnt = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (m_busy && mem_rdy) exp_rdy[m_gnt] = 1'b1;
    chk("mem_vld",  64'(mem_vld),  64'(m_busy));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_size", 64'(mem_size), 64'(m_size));
    chk("req_rdy",  64'(req_rdy),  64'(exp_rdy));
    chk("req_data", 64'(req_data), 64'(mem_data));
    if (m_busy && mem_rdy) chk("rsp_data", 64'(req_data), 64'(fdat(m_addr)));
  endtask

  // Advance the model by one clock using the inputs present this cycle
  task automatic model_update();
    bit done;
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (mem_vld && mem_rdy) mem_cnt = 0;
    else if (mem_vld) mem_cnt++;
    done = m_busy && mem_rdy;
    if (done) done_q.push_back(m_gnt);
    if (!m_busy || done) begin
      w = -1;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_last + i) % N;
        if (w < 0 && req_vld[k] && !(done && k == m_gnt)) w = k;
      end
      if (w >= 0) begin
        m_busy = 1'b1;
        m_gnt  = w;
        m_last = w;
        m_addr = req_addr[w*WA +: WA];
        m_size = req_size[w*2 +: 2];
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
    last_rdy = req_rdy;
    if (gap_mon != 0 && !mem_vld) gap_cnt++;
    model_update();
  endtask

  task automatic drive_mem();
    case (mem_mode)
      0:       mem_rdy = mem_vld && (mem_cnt >= 1);
      1:       mem_rdy = mem_vld ? (mem_cnt >= 1 && $urandom_range(0, 2) != 0)
                                 : ($urandom_range(0, 7) == 0);
      default: mem_rdy = 1'b0;
    endcase
    mem_data = mem_vld ? fdat(mem_addr) : WD'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [1:0] s);
    req_vld[k]          = 1'b1;
    req_addr[k*WA +: WA] = a;
    req_size[k*2 +: 2]   = s;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_vld  = '0;
    mem_mode = 0;
    mem_rdy  = 1'b0;
    gap_mon  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_q.delete();
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (done_q.size() < n && c < budget) begin
      sample();
      tick();
      c++;
    end
    if (done_q.size() < n) chk("run_timeout", 64'(done_q.size()), 64'(n));
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      if (req_vld[k]) begin
        if (last_rdy[k]) begin
          if ($urandom_range(0, 1) == 1) set_req(k, $urandom, 2'($urandom_range(0, 2)));
          else req_vld[k] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          req_vld[k] = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(k, $urandom, 2'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int idx;
    rst_n    = 1'b0;
    req_vld  = '0;
    req_addr = '0;
    req_size = '0;
    mem_rdy  = 1'b0;
    mem_data = '0;
    mem_mode = 0;
    gap_mon  = 0;
    gap_cnt  = 0;
    last_rdy = '0;
    model_reset();

    // reset held with requests pending, then requester 0 wins first
    set_req(0, 32'h0000_1000, 2'd2);
    set_req(1, 32'h0000_2000, 2'd2);
    repeat (3) begin
      sample();
      chk("rst_mem_vld",  64'(mem_vld),  64'd0);
      chk("rst_req_rdy",  64'(req_rdy),  64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      tick();
    end
    rst_n = 1'b1;
    run_until(2, 50);
    chk("rst_first_gnt",  64'(qat(0)), 64'd0);
    chk("rst_second_gnt", 64'(qat(1)), 64'd1);

    // single requester latency
    do_reset();
    set_req(1, 32'h0000_4000, 2'd1);
    sample();
    chk("single_t0_vld", 64'(mem_vld), 64'd0);
    tick();
    sample();
    chk("single_t1_vld",  64'(mem_vld),  64'd1);
    chk("single_t1_addr", 64'(mem_addr), 64'h4000);
    chk("single_t1_size", 64'(mem_size), 64'd1);
    chk("single_t1_rdy",  64'(req_rdy),  64'd0);
    tick();
    sample();
    chk("single_t2_rdy",  64'(req_rdy),  64'b010);
    chk("single_t2_data", 64'(req_data), 64'(fdat(32'h0000_4000)));
    tick();
    req_vld = '0;
    sample();
    chk("single_t3_idle", 64'(mem_vld), 64'd0);
    tick();

    // two-way contention, random memory latency, no bubbles
    do_reset();
    mem_mode = 1;
    set_req(0, 32'h0000_0100, 2'd2);
    set_req(1, 32'h0000_0200, 2'd2);
    sample();
    tick();
    gap_cnt = 0;
    gap_mon = 1;
    run_until(6, 200);
    gap_mon = 0;
    chk("rr2_gap", 64'(gap_cnt), 64'd0);
    for (int i = 0; i < 6; i++) chk("rr2_order", 64'(qat(i)), 64'(i % 2));

    // fairness with all three requesting
    do_reset();
    mem_mode = 1;
    set_req(0, 32'h0000_0a00, 2'd0);
    set_req(1, 32'h0000_0b00, 2'd1);
    set_req(2, 32'h0000_0c00, 2'd2);
    run_until(9, 300);
    for (int i = 0; i < 9; i++) chk("rr3_order", 64'(qat(i)), 64'(i % 3));

    // 0 and 2 alternate; late requester 1 served within two grants
    do_reset();
    set_req(0, 32'h0000_1100, 2'd2);
    set_req(2, 32'h0000_3300, 2'd2);
    run_until(4, 50);
    chk("skip_o0", 64'(qat(0)), 64'd0);
    chk("skip_o1", 64'(qat(1)), 64'd2);
    chk("skip_o2", 64'(qat(2)), 64'd0);
    chk("skip_o3", 64'(qat(3)), 64'd2);
    start = done_q.size();
    set_req(1, 32'h0000_2200, 2'd2);
    run_until(start + 3, 50);
    idx = -1;
    for (int i = done_q.size() - 1; i >= start; i--) if (qat(i) == 1) idx = i;
    chk("late_req_served", 64'(idx >= 0 && (idx - start) <= 2), 64'd1);

    // early drop: transfer still completes and pulses rdy once
    do_reset();
    mem_mode = 2;
    set_req(0, 32'h0000_0080, 2'd1);
    sample();
    tick();
    req_vld[0] = 1'b0;
    repeat (3) begin
      sample();
      chk("drop_hold_vld",  64'(mem_vld),  64'd1);
      chk("drop_hold_addr", 64'(mem_addr), 64'h80);
      tick();
    end
    mem_mode = 0;
    drive_mem();
    sample();
    chk("drop_rdy", 64'(req_rdy), 64'b001);
    tick();
    sample();
    chk("drop_idle",   64'(mem_vld), 64'd0);
    chk("drop_no_rdy", 64'(req_rdy), 64'd0);
    tick();

    // asynchronous reset in the middle of a transfer
    do_reset();
    mem_mode = 2;
    set_req(0, 32'h0000_0300, 2'd2);
    sample();
    tick();
    sample();
    mem_rdy  = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    rst_n    = 1'b0;
    #1;
    chk("mrst_mem_vld",  64'(mem_vld),  64'd0);
    chk("mrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mrst_mem_size", 64'(mem_size), 64'd0);
    chk("mrst_req_rdy",  64'(req_rdy),  64'd0);
    model_reset();
    req_vld = '0;
    mem_rdy = 1'b0;
    tick();
    sample();
    tick();
    rst_n    = 1'b1;
    mem_mode = 0;
    done_q.delete();
    set_req(1, 32'h0000_5000, 2'd0);
    sample();
    chk("mrst_t0_vld", 64'(mem_vld), 64'd0);
    tick();
    sample();
    chk("mrst_t1_vld",  64'(mem_vld),  64'd1);
    chk("mrst_t1_addr", 64'(mem_addr), 64'h5000);
    tick();
    sample();
    chk("mrst_t2_rdy",  64'(req_rdy),  64'b010);
    chk("mrst_t2_data", 64'(req_data), 64'(fdat(32'h0000_5000)));
    tick();
    req_vld = '0;

    // randomized traffic against the model
    do_reset();
    mem_mode = 1;
    repeat (3000) begin
      sample();
      tick();
      drive_reqs();
    end
    chk("rand_progress", 64'(done_q.size() > 100), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
